// File: rtl/kbd_pkg.sv
// Shared PS/2 definitions for the keyboard host receiver and transmitter.
package kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic odd_par_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronisers for both PS/2 lines plus ps2_clk falling-edge detect.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic fedg_o,
    output logic dat_o
);

    // Bit 0 is the first stage; both lines reset to the idle-high level.
    logic [2:0] clk_q;
    logic [2:0] dat_q;
    logic       unused_dat_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_q <= '1;
            dat_q <= '1;
        end else begin
            clk_q <= {clk_q[1:0], ps2_clk_i};
            dat_q <= {dat_q[1:0], ps2_dat_i};
        end
    end

    assign fedg_o        = clk_q[2] & ~clk_q[1];
    assign dat_o         = dat_q[1];
    assign unused_dat_s2 = dat_q[2];

endmodule

// File: rtl/kbd_host_rx.sv
// PS/2 host receive path: frames device bytes, checks parity/stop/timeout.
// Optional build macro KBD_RX_INHIBIT_EN holds the device off while a byte is pending.
module kbd_host_rx
    import kbd_pkg::*;
#(
    parameter int TOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rx_en,
    input  logic       rx_rdy,
    output logic       rx_vld,
    output logic [7:0] rx_dat,
    output logic       par_err,
    output logic       frm_err,
    output logic       tout_err,
    output logic       ovr_err,
    output logic       busy,
    output logic       clk_oe
);

    localparam int             TW      = (TOUT_CYC > 1) ? $clog2(TOUT_CYC) : 1;
    localparam logic [TW-1:0]  TLIM    = TW'(TOUT_CYC - 1);
    localparam logic [3:0]     PAR_IDX = 4'(FRAME_BITS - 2);

    logic fedg;
    logic dat_s;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .fedg_o    (fedg),
        .dat_o     (dat_s)
    );

    rx_state_e     state_q;
    logic [3:0]    bcnt_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    shf_q;
    logic          par_q;
    logic          stop_q;
    logic          rx_vld_q;
    logic [7:0]    rx_dat_q;
    logic          par_err_q;
    logic          frm_err_q;
    logic          tout_err_q;
    logic          ovr_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            shf_q      <= '0;
            par_q      <= 1'b0;
            stop_q     <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_dat_q   <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tout_err_q <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tout_err_q <= 1'b0;
            ovr_err_q  <= 1'b0;
            if (rx_vld_q && rx_rdy)
                rx_vld_q <= 1'b0;

            if (!rx_en) begin
                state_q <= RX_IDLE;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        if (fedg && dat_s == START_BIT) begin
                            state_q <= RX_RECV;
                            bcnt_q  <= 4'd1;
                            tcnt_q  <= '0;
                        end
                    end
                    RX_RECV: begin
                        if (fedg) begin
                            tcnt_q <= '0;
                            bcnt_q <= bcnt_q + 4'd1;
                            if (bcnt_q < PAR_IDX)
                                shf_q <= {dat_s, shf_q[7:1]};
                            else if (bcnt_q == PAR_IDX)
                                par_q <= dat_s;
                            else begin
                                stop_q  <= dat_s;
                                state_q <= RX_CHECK;
                            end
                        end else if (tcnt_q == TLIM) begin
                            // Leaving RECV here is also what keeps the counter from wrapping.
                            tout_err_q <= 1'b1;
                            state_q    <= RX_IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                    RX_CHECK: begin
                        state_q <= RX_IDLE;
                        if (stop_q != STOP_BIT)
                            frm_err_q <= 1'b1;
                        else if (!odd_par_ok(shf_q, par_q))
                            par_err_q <= 1'b1;
                        else if (rx_vld_q && !rx_rdy)
                            ovr_err_q <= 1'b1;
                        else begin
                            // Also covers accept-and-reload in the same cycle.
                            rx_vld_q <= 1'b1;
                            rx_dat_q <= shf_q;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_vld   = rx_vld_q;
    assign rx_dat   = rx_dat_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign tout_err = tout_err_q;
    assign ovr_err  = ovr_err_q;
    assign busy     = (state_q == RX_RECV);

`ifdef KBD_RX_INHIBIT_EN
    assign clk_oe = rx_vld_q && (state_q == RX_IDLE);
`else
    assign clk_oe = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_host_rx.sv
// Scoreboard bench for kbd_host_rx: PS/2 frames in, bytes and error pulses checked.
module tb_kbd_host_rx;

    localparam int TOUT = 50;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_rdy = 1'b1;
    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       par_err, frm_err, tout_err, ovr_err;
    logic       busy, clk_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q[$];
    logic [3:0] err_q[$];   // {par, frm, tout, ovr}

    kbd_host_rx #(.TOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rx_en(rx_en), .rx_rdy(rx_rdy), .rx_vld(rx_vld), .rx_dat(rx_dat),
        .par_err(par_err), .frm_err(frm_err), .tout_err(tout_err), .ovr_err(ovr_err),
        .busy(busy), .clk_oe(clk_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [3:0] errv;
        logic [3:0] ee;
        logic [7:0] eb;
        if (rst_n) begin
            errv = {par_err, frm_err, tout_err, ovr_err};
            if (errv != 4'b0) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected got=%b want=none t=%0t", errv, $time);
                end else begin
                    ee = err_q.pop_front();
                    if (errv !== ee) begin
                        errors++;
                        $display("FAIL err_kind got=%b want=%b t=%0t", errv, ee, $time);
                    end
                end
            end
            if (rx_vld && rx_rdy) begin
                checks++;
                if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected got=%h want=none t=%0t", rx_dat, $time);
                end else begin
                    eb = byte_q.pop_front();
                    if (rx_dat !== eb) begin
                        errors++;
                        $display("FAIL byte_data got=%h want=%h t=%0t", rx_dat, eb, $time);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(fr[i]);
        ps2_dat = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cyc(4);
        checks += 5;
        if (rx_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b want=0", rx_vld); end
        if (rx_dat !== 8'h00) begin errors++; $display("FAIL rst_dat got=%h want=00", rx_dat); end
        if ({par_err, frm_err, tout_err, ovr_err} !== 4'b0) begin
            errors++; $display("FAIL rst_err got=%b want=0000", {par_err, frm_err, tout_err, ovr_err});
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (clk_oe !== 1'b0) begin errors++; $display("FAIL rst_clk_oe got=%b want=0", clk_oe); end
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    // Good frame 0x1C, with the stop-bit-to-rx_vld latency measured from the line edge:
    // two cycles of synchroniser plus the two-cycle delivery path.
    task automatic test_good;
        logic [10:0] fr;
        int k;
        fr = {1'b1, 1'b0, 8'h1C, 1'b0};
        byte_q.push_back(8'h1C);
        for (int i = 0; i < 10; i++) send_bit(fr[i]);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        k = 0;
        while (k < 12 && rx_vld !== 1'b1) begin
            wait_cyc(1);
            k++;
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL vld_latency got=%0d want=4", k); end
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_parity;
        err_q.push_back(4'b1000);
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (rx_vld !== 1'b0) begin errors++; $display("FAIL par_vld got=%b want=0", rx_vld); end
    endtask

    task automatic test_framing;
        err_q.push_back(4'b0100);
        send_frame(8'hF0, 1'b0, 1'b0);
        byte_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1);
    endtask

    task automatic test_timeout;
        int k;
        err_q.push_back(4'b0010);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL tout_busy_mid got=%b want=1", busy); end
        k = HALF;
        while (k < 200 && tout_err !== 1'b1) begin
            wait_cyc(1);
            k++;
        end
        checks += 2;
        if (k != TOUT + 3) begin errors++; $display("FAIL tout_cycles got=%0d want=%0d", k, TOUT + 3); end
        if (busy !== 1'b0) begin errors++; $display("FAIL tout_busy got=%b want=0", busy); end
        wait_cyc(10);
    endtask

    task automatic test_overrun;
        rx_rdy = 1'b0;
        byte_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1);
        checks++;
        if (rx_vld !== 1'b1 || rx_dat !== 8'h12) begin
            errors++; $display("FAIL ovr_first got=%b/%h want=1/12", rx_vld, rx_dat);
        end
`ifdef KBD_RX_INHIBIT_EN
        checks++;
        if (clk_oe !== 1'b1) begin errors++; $display("FAIL inhibit_oe got=%b want=1", clk_oe); end
`else
        err_q.push_back(4'b0001);
        send_frame(8'h34, 1'b0, 1'b1);
        checks += 2;
        if (rx_dat !== 8'h12) begin errors++; $display("FAIL ovr_keep got=%h want=12", rx_dat); end
        if (clk_oe !== 1'b0) begin errors++; $display("FAIL ovr_oe got=%b want=0", clk_oe); end
`endif
        rx_rdy = 1'b1;
        wait_cyc(4);
        checks++;
        if (rx_vld !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b want=0", rx_vld); end
    endtask

    task automatic test_abort;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx_en = 1'b0;
        wait_cyc(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        rx_en = 1'b1;
        wait_cyc(TOUT + 20);
        byte_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
    endtask

    task automatic test_midreset;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
        byte_q.push_back(8'h66);
        send_frame(8'h66, 1'b0, 1'b1);
        checks++;
        if (rx_dat !== 8'h66) begin errors++; $display("FAIL midrst_dat got=%h want=66", rx_dat); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            byte_q.push_back(d);
            send_frame(d, 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset;
        test_good;
        test_parity;
        test_framing;
        test_timeout;
        test_overrun;
        test_abort;
        test_midreset;
        test_back_to_back;
        wait_cyc(20);
        checks += 2;
        if (byte_q.size() != 0) begin errors++; $display("FAIL bytes_left got=%0d want=0", byte_q.size()); end
        if (err_q.size() != 0) begin errors++; $display("FAIL errs_left got=%0d want=0", err_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
